// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, forwarding selects, widths.
// Imported by the ID/EX stage and its forwarding unit.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RA_W_DEF   = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLL  = 4'b1111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_ADDU = 4'b1010;
    localparam logic [3:0] ALU_SUBU = 4'b1110;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register.
// EX/MEM beats MEM/WB; register 0 is never forwarded.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int FWD_EN = 1
) (
    input  logic [RA_W-1:0]   i_src,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_exmem_reg_write,
    input  logic [RA_W-1:0]   i_exmem_dest,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_reg_write,
    input  logic [RA_W-1:0]   i_memwb_dest,
    input  logic [DATA_W-1:0] i_memwb_data,
    output logic [DATA_W-1:0] o_data
);

    localparam bit FWD_ON = (FWD_EN != 0);

    logic     w_exmem_hit;
    logic     w_memwb_hit;
    fwd_sel_e w_sel;

    assign w_exmem_hit = i_exmem_reg_write && (i_exmem_dest != '0)
                         && (i_exmem_dest == i_src);
    assign w_memwb_hit = i_memwb_reg_write && (i_memwb_dest != '0)
                         && (i_memwb_dest == i_src);

    always_comb begin
        w_sel = FWD_REG;
        if (FWD_ON && w_exmem_hit)
            w_sel = FWD_EXMEM;
        else if (FWD_ON && w_memwb_hit)
            w_sel = FWD_MEMWB;
    end

    always_comb begin
        o_data = i_reg_data;
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_data;
            default:   o_data = i_reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding
// and load-use hazard detection.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [RA_W-1:0]   exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [RA_W-1:0]   memwb_dest,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_x,
    output logic [DATA_W-1:0] ex_y,
    output logic [4:0]        ex_shamt,
    output logic [3:0]        ex_alu_ctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [RA_W-1:0]   ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    logic              r_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [RA_W-1:0]   r_rs;
    logic [RA_W-1:0]   r_rt;
    logic [RA_W-1:0]   r_dest;
    logic [4:0]        r_shamt;
    logic [3:0]        r_alu_ctrl;
    logic              r_alu_src;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;

    logic              w_hazard;
    logic              w_bubble;
    logic              w_rw;
    logic [RA_W-1:0]   w_dest;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    assign w_hazard = r_valid && r_mem_read && (r_dest != '0) && id_valid
                      && ((r_dest == id_rs)
                          || (id_uses_rt && (r_dest == id_rt)));
    assign load_use_stall = w_hazard && !flush;
    assign w_bubble = flush || load_use_stall;

    assign w_rw   = id_reg_write && id_valid;
    assign w_dest = !w_rw ? '0 : (id_reg_dst ? id_rd : id_rt);

    // Bubbles clear only valid/control/dest; operand data is don't-care.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_dest       <= '0;
            r_shamt      <= '0;
            r_alu_ctrl   <= '0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!hold) begin
            if (w_bubble) begin
                r_valid      <= 1'b0;
                r_dest       <= '0;
                r_reg_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
            end else begin
                r_valid      <= id_valid;
                r_rs_data    <= id_rs_data;
                r_rt_data    <= id_rt_data;
                r_imm        <= id_imm;
                r_rs         <= id_rs;
                r_rt         <= id_rt;
                r_dest       <= w_dest;
                r_shamt      <= id_shamt;
                r_alu_ctrl   <= id_alu_ctrl;
                r_alu_src    <= id_alu_src;
                r_reg_write  <= w_rw;
                r_mem_read   <= id_mem_read && id_valid;
                r_mem_write  <= id_mem_write && id_valid;
                r_mem_to_reg <= id_mem_to_reg && id_valid;
            end
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs (
        .i_src             (r_rs),
        .i_reg_data        (r_rs_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_dest      (exmem_dest),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_dest      (memwb_dest),
        .i_memwb_data      (memwb_data),
        .o_data            (w_fwd_rs)
    );

    fwd_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rt (
        .i_src             (r_rt),
        .i_reg_data        (r_rt_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_dest      (exmem_dest),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_dest      (memwb_dest),
        .i_memwb_data      (memwb_data),
        .o_data            (w_fwd_rt)
    );

    assign ex_valid      = r_valid;
    assign ex_x          = w_fwd_rs;
    assign ex_y          = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_shamt      = r_shamt;
    assign ex_alu_ctrl   = r_alu_ctrl;
    assign ex_dest       = r_dest;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts EX outputs,
// expectations are queued at drive time and compared after each edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_dst, id_uses_rt;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_data;
    logic        load_use_stall, ex_valid;
    logic [31:0] ex_x, ex_y, ex_store_data;
    logic [4:0]  ex_shamt, ex_dest;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_alu_ctrl(id_alu_ctrl),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest),
        .memwb_data(memwb_data),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_x(ex_x), .ex_y(ex_y), .ex_shamt(ex_shamt),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] x, y, sd;
        logic [4:0]  shamt, dest;
        logic [3:0]  ctrl;
        logic        rw, mr, mw, m2r;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference ID/EX contents
    logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_dest, m_shamt;
    logic [3:0]  m_ctrl;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(logic [4:0] src, logic [31:0] rd);
        if (exmem_reg_write && exmem_dest != 0 && exmem_dest == src)
            return exmem_result;
        if (memwb_reg_write && memwb_dest != 0 && memwb_dest == src)
            return memwb_data;
        return rd;
    endfunction

    task automatic model_reset();
        {m_valid, m_src, m_rw, m_mr, m_mw, m_m2r} = '0;
        m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_dest = 0; m_shamt = 0; m_ctrl = 0;
    endtask

    task automatic set_id(logic v, logic [4:0] rs, logic [4:0] rt,
                          logic [4:0] rd, logic [31:0] rsd, logic [31:0] rtd,
                          logic [31:0] imm, logic [3:0] ctrl, logic src,
                          logic dst, logic urt, logic rw, logic mr,
                          logic mw, logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_ctrl = ctrl; id_alu_src = src; id_reg_dst = dst;
        id_uses_rt = urt; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_mem_to_reg = m2r; id_shamt = 5'd0;
    endtask

    task automatic set_fwd(logic ew, logic [4:0] ed, logic [31:0] er,
                           logic mw, logic [4:0] md, logic [31:0] mdat);
        exmem_reg_write = ew; exmem_dest = ed; exmem_result = er;
        memwb_reg_write = mw; memwb_dest = md; memwb_data = mdat;
    endtask

    // called at posedge+1 with inputs already driven; returns at next posedge+1
    task automatic cycle();
        logic hz;
        exp_t e, g;
        #1;
        hz = m_valid && m_mr && m_dest != 0 && id_valid
             && (m_dest == id_rs || (id_uses_rt && m_dest == id_rt))
             && !flush;
        check("stall", {31'd0, load_use_stall}, {31'd0, hz});
        if (!rst) begin
            model_reset();
        end else if (hold) begin
        end else if (flush || hz) begin
            m_valid = 0; m_dest = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
        end else begin
            m_valid = id_valid;
            m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_shamt = id_shamt;
            m_ctrl = id_alu_ctrl; m_src = id_alu_src;
            m_rw = id_reg_write && id_valid;
            m_mr = id_mem_read && id_valid;
            m_mw = id_mem_write && id_valid;
            m_m2r = id_mem_to_reg && id_valid;
            m_dest = !m_rw ? 5'd0 : (id_reg_dst ? id_rd : id_rt);
        end
        e.valid = m_valid;
        e.x = fwd(m_rs, m_rsd);
        e.sd = fwd(m_rt, m_rtd);
        e.y = m_src ? m_imm : e.sd;
        e.shamt = m_shamt; e.dest = m_dest; e.ctrl = m_ctrl;
        e.rw = m_rw; e.mr = m_mr; e.mw = m_mw; e.m2r = m_m2r;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            g = q.pop_front();
            check("valid", {31'd0, ex_valid}, {31'd0, g.valid});
            check("x", ex_x, g.x);
            check("y", ex_y, g.y);
            check("store", ex_store_data, g.sd);
            check("shamt", {27'd0, ex_shamt}, {27'd0, g.shamt});
            check("dest", {27'd0, ex_dest}, {27'd0, g.dest});
            check("ctrl", {28'd0, ex_alu_ctrl}, {28'd0, g.ctrl});
            check("ctl_bits", {28'd0, ex_reg_write, ex_mem_read,
                               ex_mem_write, ex_mem_to_reg},
                  {28'd0, g.rw, g.mr, g.mw, g.m2r});
        end
    endtask

    initial begin
        rst = 1'b0; hold = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_dest", {27'd0, ex_dest}, 32'd0);
        check("rst_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // EX/MEM forward into sub rs=r3
        set_id(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 0, 4'b0010, 0, 1, 1, 1, 0, 0, 0);
        cycle();
        set_fwd(1, 5'd3, 32'h10, 0, 0, 0);
        set_id(1, 5'd3, 5'd2, 5'd8, 32'h5, 32'h7, 0, 4'b0110, 0, 1, 1, 1, 0, 0, 0);
        cycle();
        check("exmem_x", ex_x, 32'h10);
        check("sub_ctrl", {28'd0, ex_alu_ctrl}, 32'h6);

        // double hazard on rt=r4
        set_fwd(1, 5'd4, 32'hAAAA, 1, 5'd4, 32'hBBBB);
        set_id(1, 5'd1, 5'd4, 5'd9, 32'h11, 32'h44, 0, 4'b0010, 0, 1, 1, 1, 0, 0, 0);
        cycle();
        check("dbl_y", ex_y, 32'hAAAA);
        set_fwd(1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB);
        #1;
        check("r0_y", ex_y, 32'h44);
        #1;

        // load-use: lw r5, then add r5
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 5'd1, 5'd5, 5'd0, 32'h100, 0, 32'h4, 4'b0010, 1, 0, 0, 1, 1, 0, 1);
        cycle();
        set_id(1, 5'd5, 5'd2, 5'd7, 32'h0, 32'h3, 0, 4'b0010, 0, 1, 1, 1, 0, 0, 0);
        #1;
        check("lu_stall", {31'd0, load_use_stall}, 32'd1);
        #1;
        cycle();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        set_fwd(0, 0, 0, 1, 5'd5, 32'hDEAD);
        cycle();
        check("lu_fwd_x", ex_x, 32'hDEAD);
        check("lu_valid", {31'd0, ex_valid}, 32'd1);

        // flush beats stall
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 5'd1, 5'd5, 5'd0, 32'h100, 0, 32'h4, 4'b0010, 1, 0, 0, 1, 1, 0, 1);
        cycle();
        set_id(1, 5'd5, 5'd2, 5'd7, 32'h0, 32'h3, 0, 4'b0010, 0, 1, 1, 1, 0, 0, 0);
        flush = 1;
        cycle();
        check("fl_bubble", {31'd0, ex_valid}, 32'd0);
        flush = 0;
        cycle();
        hold = 1; flush = 1;
        set_id(1, 5'd9, 5'd9, 5'd9, 32'h9, 32'h9, 0, 4'b0001, 0, 1, 1, 1, 0, 0, 0);
        cycle();
        check("hold_fl_valid", {31'd0, ex_valid}, 32'd1);
        check("hold_fl_dest", {27'd0, ex_dest}, 32'd7);
        hold = 0; flush = 0;

        // sw with MEM/WB-forwarded store data
        set_fwd(0, 0, 0, 1, 5'd6, 32'h1234);
        set_id(1, 5'd1, 5'd6, 5'd0, 32'h200, 32'h0, 32'h8, 4'b0010, 1, 0, 1, 0, 0, 1, 0);
        cycle();
        check("sw_y", ex_y, 32'h8);
        check("sw_sd", ex_store_data, 32'h1234);
        check("sw_mw", {31'd0, ex_mem_write}, 32'd1);
        check("sw_dest", {27'd0, ex_dest}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            hold = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 1), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 4'($urandom),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1));
            id_shamt = 5'($urandom);
            set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        hold = 0; flush = 0;

        // mid-stream async reset
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 0, 4'b0010, 0, 1, 1, 1, 0, 0, 0);
        cycle();
        check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("arst_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_rw", {31'd0, ex_reg_write}, 32'd0);
        check("arst_dest", {27'd0, ex_dest}, 32'd0);
        @(posedge clk); #1;
        cycle();
        check("rst_hold_valid", {31'd0, ex_valid}, 32'd0);
        rst = 1'b1;
        cycle();
        check("post_rst_valid", {31'd0, ex_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
